// File: rtl/qu_common.sv
// ============================================================================
// qu_common : shared types for the fetch/PC-counter slice
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

package qu_common;

   localparam int c_PC_WIDTH    = 32;
   localparam int c_INSTR_WIDTH = 32;

   typedef logic [c_PC_WIDTH-1:0]    pc_t;
   typedef logic [c_INSTR_WIDTH-1:0] instr_t;

   typedef struct packed {
      pc_t    pc;
      instr_t instr;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/qu_sync_fifo.sv
// ============================================================================
// qu_sync_fifo : synchronous FIFO with clear, async active-low reset
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

module qu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH) + 1;
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign empty    = (r_count == '0);
   assign full     = (r_count == c_CNT_FULL);
   assign count    = r_count;
   assign pop_data = r_mem[r_rd_ptr];

   // A push into a full FIFO is only taken when a pop frees the slot.
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !clear) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : in-order instruction fetch with credit-based fetch queue
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import qu_common::*;
#(
   parameter int PC_WIDTH        = c_PC_WIDTH,
   parameter int INSTR_WIDTH     = c_INSTR_WIDTH,
   parameter int FQ_DEPTH        = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PC_WIDTH-1:0]    pc_in,
   output logic                   pc_en,
   input  logic                   flush,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [PC_WIDTH-1:0]    imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
   output logic                   dec_valid,
   input  logic                   dec_ready,
   output logic [PC_WIDTH-1:0]    dec_pc,
   output logic [INSTR_WIDTH-1:0] dec_instr
);

   localparam int c_FQ_CNT_W = $clog2(FQ_DEPTH) + 1;
   localparam int c_OS_CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int c_SUM_W    = ((c_FQ_CNT_W > c_OS_CNT_W) ? c_FQ_CNT_W : c_OS_CNT_W) + 1;
   localparam logic [c_OS_CNT_W-1:0] c_OS_ONE = c_OS_CNT_W'(1);

   logic [c_OS_CNT_W-1:0] r_live_cnt;
   logic [c_OS_CNT_W-1:0] r_drop_cnt;
   logic [c_FQ_CNT_W-1:0] w_fq_count;
   logic [c_OS_CNT_W-1:0] w_tag_count;
   logic [c_SUM_W-1:0]    w_fq_plus_live;
   logic [c_SUM_W-1:0]    w_in_flight;
   logic                  w_fire;
   logic                  w_rsp_keep;
   logic                  w_dec_pop;
   logic                  w_fq_full;
   logic                  w_fq_empty;
   logic                  w_tag_full;
   logic                  w_tag_empty;
   pc_t                   w_tag_head;
   fetch_entry_t          w_fq_in;
   fetch_entry_t          w_fq_head;

   assign w_fq_plus_live = c_SUM_W'(w_fq_count) + c_SUM_W'(r_live_cnt);
   assign w_in_flight    = c_SUM_W'(r_live_cnt) + c_SUM_W'(r_drop_cnt);

   // Live requests reserve queue space so a kept response always has a slot.
   assign imem_req_valid = rst && !flush
                           && (w_fq_plus_live < c_SUM_W'(FQ_DEPTH))
                           && (w_in_flight < c_SUM_W'(MAX_OUTSTANDING));
   assign w_fire        = imem_req_valid && imem_req_ready;
   assign pc_en         = w_fire;
   assign imem_req_addr = pc_in;

   assign w_rsp_keep = imem_rsp_valid && !flush && (r_drop_cnt == '0);

   assign dec_valid = !w_fq_empty && !flush;
   assign w_dec_pop = dec_valid && dec_ready;
   assign dec_pc    = w_fq_head.pc;
   assign dec_instr = w_fq_head.instr;

   assign w_fq_in.pc    = w_tag_head;
   assign w_fq_in.instr = imem_rsp_data;

   qu_sync_fifo #(
      .WIDTH (PC_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (w_fire),
      .push_data (pc_in),
      .pop       (w_rsp_keep),
      .pop_data  (w_tag_head),
      .count     (w_tag_count),
      .full      (w_tag_full),
      .empty     (w_tag_empty)
   );

   qu_sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (w_rsp_keep),
      .push_data (w_fq_in),
      .pop       (w_dec_pop),
      .pop_data  (w_fq_head),
      .count     (w_fq_count),
      .full      (w_fq_full),
      .empty     (w_fq_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_live_cnt <= '0;
         r_drop_cnt <= '0;
      end else if (flush) begin
         // Everything live becomes stale; a response landing now is one of them.
         r_live_cnt <= '0;
         r_drop_cnt <= r_drop_cnt + r_live_cnt
                       - {{(c_OS_CNT_W-1){1'b0}}, imem_rsp_valid};
      end else begin
         if (imem_rsp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - c_OS_ONE;
         end
         unique case ({w_fire, w_rsp_keep})
            2'b10:   r_live_cnt <= r_live_cnt + c_OS_ONE;
            2'b01:   r_live_cnt <= r_live_cnt - c_OS_ONE;
            default: r_live_cnt <= r_live_cnt;
         endcase
      end
   end

   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> ((r_live_cnt != '0) || (r_drop_cnt != '0)));
   a_rsp_room: assert property (@(posedge clk) disable iff (!rst)
      w_rsp_keep |-> (!w_fq_full && !w_tag_empty));
   a_tag_room: assert property (@(posedge clk) disable iff (!rst)
      w_fire |-> !w_tag_full);
   a_tag_track: assert property (@(posedge clk) disable iff (!rst)
      w_tag_count == r_live_cnt);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : scoreboard bench with PC-counter and memory models
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   localparam logic [31:0] PC_RESET = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_en;
   logic        flush;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;

   fetch_unit #(
      .PC_WIDTH        (32),
      .INSTR_WIDTH     (32),
      .FQ_DEPTH        (4),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_in          (pc_in),
      .pc_en          (pc_en),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_pc         (dec_pc),
      .dec_instr      (dec_instr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          n_fire  = 0;
   int          n_rsp   = 0;
   int          n_pop   = 0;
   int          n_pcen  = 0;
   int          max_os  = 0;
   int          lat     = 2;
   logic [31:0] redirect_pc = '0;
   logic        capture_first = 1'b0;
   logic [31:0] first_fire_addr = '0;
   logic [31:0] sb_q[$];
   mreq_t       mq[$];

   // Instruction word the memory returns for an address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_fires(input int target);
      for (int i = 0; i < 300 && n_fire < target; i++) tick();
      check("fire_count", n_fire, target);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && sb_q.size() != 0; i++) tick();
      check("sb_drained", sb_q.size(), 0);
   endtask

   task automatic expect_run(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) sb_q.push_back(start + i);
   endtask

   // PC counter and fixed-latency in-order memory
   logic        s_fire, s_pcen, s_flush, s_rsp;
   logic [31:0] s_addr, s_redir;
   initial begin
      forever begin
         @(negedge clk);
         s_fire  = rst && imem_req_valid && imem_req_ready;
         s_pcen  = rst && pc_en;
         s_addr  = imem_req_addr;
         s_flush = rst && flush;
         s_redir = redirect_pc;
         s_rsp   = rst && imem_rsp_valid;
         if (rst) begin
            check("pc_en_eq_fire", {31'b0, pc_en}, {31'b0, s_fire});
            if (s_fire) check("req_addr", imem_req_addr, pc_in);
            if (flush) begin
               check("flush_req_valid", {31'b0, imem_req_valid}, 32'd0);
               check("flush_dec_valid", {31'b0, dec_valid}, 32'd0);
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!rst) begin
            mq.delete();
            n_rsp          = n_fire;
            pc_in          = PC_RESET;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end else begin
            if (s_fire) begin
               n_fire++;
               if (capture_first) begin
                  first_fire_addr = s_addr;
                  capture_first   = 1'b0;
               end
               mq.push_back('{s_addr, cyc + lat - 1});
            end
            if (s_pcen) n_pcen++;
            if (s_rsp) n_rsp++;
            if (n_fire - n_rsp > max_os) max_os = n_fire - n_rsp;
            if (s_flush)     pc_in = s_redir;
            else if (s_pcen) pc_in = pc_in + 32'd1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(mq[0].addr);
               void'(mq.pop_front());
            end else begin
               imem_rsp_valid = 1'b0;
               imem_rsp_data  = '0;
            end
         end
      end
   end

   // Scoreboard monitor
   logic [31:0] m_exp;
   initial begin
      forever begin
         @(negedge clk);
         if (rst && dec_valid && dec_ready) begin
            n_pop++;
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL dec_unexpected: got pc %h, expected no output", dec_pc);
            end else begin
               m_exp = sb_q.pop_front();
               check("dec_pc", dec_pc, m_exp);
               check("dec_instr", dec_instr, mem_word(m_exp));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   int base, base2, p0, r0, t_first, t_last, pcen0;
   initial begin
      rst = 1'b0; flush = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;
      pc_in = PC_RESET; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      #3;
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_pc_en", {31'b0, pc_en}, 32'd0);
      check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
      imem_req_ready = 1'b0;
      dec_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // Streaming, latency 2
      lat = 2; base = n_fire; p0 = n_pop; pcen0 = n_pcen;
      t_first = -1; t_last = -1;
      expect_run(32'h100, 12);
      imem_req_ready = 1'b1; dec_ready = 1'b1;
      for (int i = 0; i < 100 && n_pop < p0 + 12; i++) begin
         tick();
         if (n_fire >= base + 12) imem_req_ready = 1'b0;
         if (t_first < 0 && n_pop >= p0 + 1) t_first = cyc;
         if (n_pop >= p0 + 12) t_last = cyc;
      end
      imem_req_ready = 1'b0;
      check("stream_fires", n_fire - base, 12);
      check("stream_pc_en", n_pcen - pcen0, 12);
      check("stream_throughput", t_last - t_first, 11);
      wait_drain();

      // Back-pressure
      base = n_fire; p0 = n_pop;
      expect_run(32'h10C, 4);
      dec_ready = 1'b0; imem_req_ready = 1'b1;
      repeat (10) tick();
      check("bp_fires", n_fire - base, 4);
      check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      repeat (8) tick();
      check("bp_single_pop", n_pop - p0, 1);
      check("bp_refill", n_fire - base, 5);
      check("bp_req_valid2", {31'b0, imem_req_valid}, 32'd0);
      imem_req_ready = 1'b0;
      expect_run(32'h110, 1);
      dec_ready = 1'b1;
      wait_drain();

      // Flush with three in flight and one queued
      redirect_pc = 32'h1FF; flush = 1'b1; tick(); flush = 1'b0;
      lat = 4; dec_ready = 1'b0; base = n_fire;
      imem_req_ready = 1'b1;
      wait_fires(base + 1);
      imem_req_ready = 1'b0;
      repeat (3) tick();
      imem_req_ready = 1'b1;
      wait_fires(base + 4);
      redirect_pc = 32'h400; flush = 1'b1; dec_ready = 1'b1;
      expect_run(32'h400, 4);
      base2 = n_fire;
      tick();
      flush = 1'b0;
      wait_fires(base2 + 4);
      imem_req_ready = 1'b0;
      wait_drain();

      // Response arriving in the flush cycle
      lat = 2; dec_ready = 1'b1; base = n_fire;
      imem_req_ready = 1'b1;
      wait_fires(base + 2);
      redirect_pc = 32'h600; flush = 1'b1;
      expect_run(32'h600, 2);
      tick();
      flush = 1'b0;
      base2 = n_fire;
      wait_fires(base2 + 2);
      imem_req_ready = 1'b0;
      wait_drain();

      // Outstanding limit and back-to-back flushes, latency 5
      lat = 5; dec_ready = 1'b0; max_os = 0; r0 = n_rsp;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 50 && n_rsp < r0 + 1; i++) tick();
      check("os_first_rsp", n_rsp - r0, 1);
      redirect_pc = 32'h700; flush = 1'b1;
      tick();
      redirect_pc = 32'h800;
      tick();
      flush = 1'b0; dec_ready = 1'b1;
      expect_run(32'h800, 8);
      base2 = n_fire;
      wait_fires(base2 + 8);
      imem_req_ready = 1'b0;
      wait_drain();
      check("os_max", max_os, 4);

      // Async reset mid-operation
      lat = 2; dec_ready = 1'b1; base = n_fire;
      expect_run(32'h808, 8);
      imem_req_ready = 1'b1;
      wait_fires(base + 5);
      #1;
      rst = 1'b0;
      #1;
      check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("arst_pc_en", {31'b0, pc_en}, 32'd0);
      check("arst_dec_valid", {31'b0, dec_valid}, 32'd0);
      sb_q.delete();
      repeat (2) tick();
      capture_first = 1'b1;
      expect_run(PC_RESET, 4);
      base = n_fire;
      rst = 1'b1;
      wait_fires(base + 4);
      imem_req_ready = 1'b0;
      check("arst_first_addr", first_fire_addr, PC_RESET);
      wait_drain();

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
